fp_mul_host: RTL and testbench



---
 rtl/fp_mul_host_if.sv | 41 ++++
 rtl/fp_mul_host.sv | 156 +++++++++++++++
 tb/tb_fp_mul_host.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_host_if.sv
// Handshake bundle between a job source, the multiplier host controller and one multiplier.
// The master view belongs to the host; the slave view is the job source plus multiplier side.
interface fp_mul_host_if;
    localparam int unsigned DW = 32;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_z;
    logic          res_nan;
    logic          res_inf;
    logic          res_zero;

    logic [DW-1:0] mul_a;
    logic          mul_a_stb;
    logic          mul_a_ack;
    logic [DW-1:0] mul_b;
    logic          mul_b_stb;
    logic          mul_b_ack;
    logic [DW-1:0] mul_z;
    logic          mul_z_stb;
    logic          mul_z_ack;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, res_ready,
        input  mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        output cmd_ready, res_valid, res_z, res_nan, res_inf, res_zero,
        output mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, res_ready,
        output mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        input  cmd_ready, res_valid, res_z, res_nan, res_inf, res_zero,
        input  mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
    );
endinterface

// File: rtl/fp_mul_host.sv
// Initiator for the multiplier stb/ack protocol: sends A then B, collects Z, and holds
// the result with classification flags. Per-phase watchdog and a wrapping transaction count.
module fp_mul_host #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_mul_host_if.master     bus,
    output logic              busy,
    output logic [CNT_W-1:0]  txn_count,
    output logic              err_timeout
);
    localparam int unsigned DW      = 32;
    localparam int unsigned WD_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WD_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, ERROR} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d, res_z_q, res_z_d;
    logic              a_stb_q, a_stb_d, b_stb_q, b_stb_d, z_ack_q, z_ack_d;
    logic              res_valid_q, res_valid_d, err_q, err_d;
    logic [CNT_W-1:0]  txn_q, txn_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              res_take, wd_hit, tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_z_q     <= '0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
            z_ack_q     <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            txn_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_z_q     <= res_z_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
            z_ack_q     <= z_ack_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            txn_q       <= txn_d;
            wd_q        <= wd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_z_d     = res_z_q;
        a_stb_d     = a_stb_q;
        b_stb_d     = b_stb_q;
        z_ack_d     = z_ack_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        txn_d       = txn_q;
        wd_d        = wd_q;
        tick        = 1'b0;
        res_take    = res_valid_q && bus.res_ready;
        wd_hit      = WD_EN && (wd_q == WD_W'(WD_LAST));

        if (res_take) res_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    mul_a_d = bus.cmd_a;
                    mul_b_d = bus.cmd_b;
                    a_stb_d = 1'b1;
                    wd_d    = '0;
                    state_d = SEND_A;
                end
            end
            SEND_A: begin
                if (a_stb_q && bus.mul_a_ack) begin
                    a_stb_d = 1'b0;
                    b_stb_d = 1'b1;
                    wd_d    = '0;
                    state_d = SEND_B;
                end else begin
                    tick = 1'b1;
                end
            end
            SEND_B: begin
                if (b_stb_q && bus.mul_b_ack) begin
                    b_stb_d = 1'b0;
                    wd_d    = '0;
                    state_d = WAIT_Z;
                end else begin
                    tick = 1'b1;
                end
            end
            WAIT_Z: begin
                if (bus.mul_z_stb && z_ack_q) begin
                    res_z_d     = bus.mul_z;
                    res_valid_d = 1'b1;
                    z_ack_d     = 1'b0;
                    txn_d       = txn_q + CNT_W'(1);
                    wd_d        = '0;
                    state_d     = IDLE;
                end else if (res_valid_q && !res_take) begin
                    // Held result not yet drained: withhold ack, watchdog paused
                    z_ack_d = 1'b0;
                end else begin
                    z_ack_d = 1'b1;
                    tick    = 1'b1;
                end
            end
            ERROR: begin
                a_stb_d = 1'b0;
                b_stb_d = 1'b0;
                z_ack_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Watchdog: one increment per stalled cycle, trip on the last allowed cycle
        if (tick) begin
            if (wd_hit) begin
                err_d   = 1'b1;
                a_stb_d = 1'b0;
                b_stb_d = 1'b0;
                z_ack_d = 1'b0;
                state_d = ERROR;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_a_stb = a_stb_q;
    assign bus.mul_b_stb = b_stb_q;
    assign bus.mul_z_ack = z_ack_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_z     = res_z_q;
    assign bus.res_nan   = (res_z_q[30:23] == 8'hFF) && (res_z_q[22:0] != 23'd0);
    assign bus.res_inf   = (res_z_q[30:23] == 8'hFF) && (res_z_q[22:0] == 23'd0);
    assign bus.res_zero  = (res_z_q[30:0] == 31'd0);
    assign txn_count     = txn_q;
    assign err_timeout   = err_q;
endmodule

// File: tb/tb_fp_mul_host.sv
// Directed bench for fp_mul_host with a behavioural stb/ack multiplier responder.
module tb_fp_mul_host;
    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [3:0] txn_count;
    logic       err_timeout;

    fp_mul_host_if bus ();

    fp_mul_host #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .txn_count   (txn_count),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Multiplier responder state
    bit          b_en = 1'b1;
    bit          z_en = 1'b1;
    bit          z_pend = 1'b0;
    bit          order_bad = 1'b0;
    int          a_beats = 0;
    int          b_beats = 0;
    logic [31:0] cap_a = '0;
    logic [31:0] cap_b = '0;

    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40400000_40000000: prod = 32'h40C00000;
            64'h7F800000_00000000: prod = 32'hFFC00000;
            64'h7F800000_3F800000: prod = 32'h7F800000;
            64'h80000000_3F800000: prod = 32'h80000000;
            64'h3F800000_3F800000: prod = 32'h3F800000;
            64'h40000000_40000000: prod = 32'h40800000;
            64'h40400000_40400000: prod = 32'h41100000;
            default:               prod = a ^ b;
        endcase
    endfunction

    logic        s_a_fire, s_a_req, s_b_fire, s_b_req, s_z_fire;
    logic [31:0] s_a, s_b;

    always @(posedge clk) begin : mul_model
        s_a_fire = bus.mul_a_stb && bus.mul_a_ack;
        s_a_req  = bus.mul_a_stb && !bus.mul_a_ack;
        s_b_fire = bus.mul_b_stb && bus.mul_b_ack;
        s_b_req  = bus.mul_b_stb && !bus.mul_b_ack;
        s_z_fire = bus.mul_z_stb && bus.mul_z_ack;
        s_a      = bus.mul_a;
        s_b      = bus.mul_b;
        #1;
        if (!rst_n) begin
            bus.mul_a_ack = 1'b0;
            bus.mul_b_ack = 1'b0;
            bus.mul_z_stb = 1'b0;
            bus.mul_z     = '0;
            z_pend        = 1'b0;
        end else begin
            if (s_a_fire) begin
                cap_a = s_a;
                a_beats++;
                bus.mul_a_ack = 1'b0;
            end else begin
                bus.mul_a_ack = s_a_req;
            end
            if (s_b_fire) begin
                cap_b = s_b;
                b_beats++;
                if (b_beats != a_beats) order_bad = 1'b1;
                z_pend = 1'b1;
                bus.mul_b_ack = 1'b0;
            end else begin
                bus.mul_b_ack = s_b_req && b_en;
            end
            if (s_z_fire) bus.mul_z_stb = 1'b0;
            if (z_pend && z_en && !bus.mul_z_stb) begin
                bus.mul_z     = prod(cap_a, cap_b);
                bus.mul_z_stb = 1'b1;
                z_pend        = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.res_valid), 32'd1);
    endtask

    task automatic wait_sig(input string tag, input int which);
        int n = 0;
        while (n < 50 && !((which == 0) ? bus.mul_b_stb : bus.mul_z_ack)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'((which == 0) ? bus.mul_b_stb : bus.mul_z_ack), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_a_stb",  32'(bus.mul_a_stb), 32'd0);
        chk("rst_b_stb",  32'(bus.mul_b_stb), 32'd0);
        chk("rst_z_ack",  32'(bus.mul_z_ack), 32'd0);
        chk("rst_rvalid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_z",  bus.res_z, 32'd0);
        chk("rst_mul_a",  bus.mul_a, 32'd0);
        chk("rst_mul_b",  bus.mul_b, 32'd0);
        chk("rst_txn",    32'(txn_count), 32'd0);
        chk("rst_err",    32'(err_timeout), 32'd0);
        chk("rst_ready",  32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",   32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3.0 x 2.0
        issue(32'h40400000, 32'h40000000);
        chk("basic_busy", 32'(busy), 32'd1);
        wait_res("basic_done");
        chk("basic_z",     bus.res_z, 32'h40C00000);
        chk("basic_zero",  32'(bus.res_zero), 32'd0);
        chk("basic_inf",   32'(bus.res_inf), 32'd0);
        chk("basic_nan",   32'(bus.res_nan), 32'd0);
        chk("basic_txn",   32'(txn_count), 32'd1);
        chk("basic_cap_a", cap_a, 32'h40400000);
        chk("basic_cap_b", cap_b, 32'h40000000);
        chk("basic_order", 32'(order_bad), 32'd0);
        chk("basic_beats", 32'(b_beats), 32'd1);
        @(negedge clk);
        chk("basic_drain", 32'(bus.res_valid), 32'd0);

        // Special values
        issue(32'h7F800000, 32'h00000000);
        wait_res("nan_done");
        chk("nan_z",    bus.res_z, 32'hFFC00000);
        chk("nan_flag", 32'(bus.res_nan), 32'd1);
        chk("nan_inf",  32'(bus.res_inf), 32'd0);
        @(negedge clk);
        issue(32'h7F800000, 32'h3F800000);
        wait_res("inf_done");
        chk("inf_z",    bus.res_z, 32'h7F800000);
        chk("inf_flag", 32'(bus.res_inf), 32'd1);
        chk("inf_nan",  32'(bus.res_nan), 32'd0);
        @(negedge clk);
        issue(32'h80000000, 32'h3F800000);
        wait_res("zero_done");
        chk("zero_z",    bus.res_z, 32'h80000000);
        chk("zero_flag", 32'(bus.res_zero), 32'd1);
        @(negedge clk);
        chk("txn_four", 32'(txn_count), 32'd4);

        // Result backpressure
        bus.res_ready = 1'b0;
        issue(32'h40000000, 32'h40000000);
        wait_res("bp_first");
        issue(32'h40400000, 32'h40400000);
        repeat (20) @(negedge clk);
        chk("bp_z_stb",  32'(bus.mul_z_stb), 32'd1);
        chk("bp_z_ack",  32'(bus.mul_z_ack), 32'd0);
        chk("bp_no_err", 32'(err_timeout), 32'd0);
        chk("bp_hold_z", bus.res_z, 32'h40800000);
        chk("bp_hold_v", 32'(bus.res_valid), 32'd1);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("bp_ack_up", 32'(bus.mul_z_ack), 32'd1);
        chk("bp_clear",  32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("bp_second_v", 32'(bus.res_valid), 32'd1);
        chk("bp_second_z", bus.res_z, 32'h41100000);
        chk("bp_txn",      32'(txn_count), 32'd6);
        bus.res_ready = 1'b1;
        @(negedge clk);

        // Watchdog on a missing B ack
        b_en = 1'b0;
        issue(32'h40400000, 32'h40000000);
        wait_sig("to_b_stb", 0);
        repeat (7) @(negedge clk);
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        @(negedge clk);
        chk("to_err",   32'(err_timeout), 32'd1);
        chk("to_b_stb", 32'(bus.mul_b_stb), 32'd0);
        chk("to_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("to_sticky", 32'(err_timeout), 32'd1);
        chk("to_locked", 32'(bus.cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("to_rst_err", 32'(err_timeout), 32'd0);
        b_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while waiting for Z
        z_en = 1'b0;
        issue(32'h3F800000, 32'h3F800000);
        wait_sig("wz_ack", 1);
        rst_n = 1'b0;
        #1;
        chk("wz_rst_ack",  32'(bus.mul_z_ack), 32'd0);
        chk("wz_rst_a",    32'(bus.mul_a_stb), 32'd0);
        chk("wz_rst_b",    32'(bus.mul_b_stb), 32'd0);
        chk("wz_rst_busy", 32'(busy), 32'd0);
        chk("wz_rst_txn",  32'(txn_count), 32'd0);
        z_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'h3F800000, 32'h3F800000);
        wait_res("fresh_done");
        chk("fresh_z",   bus.res_z, 32'h3F800000);
        chk("fresh_txn", 32'(txn_count), 32'd1);
        @(negedge clk);

        // Counter wrap: 16 more transactions on a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            issue(32'h40400000, 32'h40000000);
            wait_res("wrap_done");
            @(negedge clk);
        end
        chk("wrap_txn", 32'(txn_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
